// File: rtl/crossy_robbers_keycode_queue.sv
// crossy_robbers_keycode_queue: Avalon-MM keycode event FIFO with held-key slots, status and IRQ
module crossy_robbers_keycode_queue #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 6,
  parameter int ADDR_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      ev_valid,
  output logic [WIDTH-1:0]          ev_data,
  input  logic                      ev_ready,
  output logic                      irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] held_q [CHANNELS];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d;
  logic wr, push, pop, acc, flush, ctl_wr, full, empty;
  assign wr     = chipselect & ~write_n;
  assign push   = wr && address == ADDR_W'(0);
  assign ctl_wr = wr && address == ADDR_W'(2);
  assign flush  = ctl_wr & writedata[2];
  assign full   = count_q == CW'(DEPTH);
  assign empty  = count_q == '0;
  assign pop    = ev_valid & ev_ready;
  assign acc    = push & en_q & (~full | pop);
  assign ev_valid = ~empty;
  assign ev_data  = mem_q[rd_ptr_q];
  assign irq      = irq_en_q & (~empty | ovf_q);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_port
    assign out_port[g*WIDTH +: WIDTH] = held_q[g];
  end
  // next state of pointers, occupancy and control bits; flush overrides any push or pop
  always_comb begin
    wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(acc);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d   = flush ? '0 : count_q + CW'(acc) - CW'(pop);
    ovf_d     = (ovf_q & ~(wr && address == ADDR_W'(1) && writedata[2])) | (push & en_q & ~acc);
    en_d      = ctl_wr ? writedata[0] : en_q;
    irq_en_d  = ctl_wr ? writedata[1] : irq_en_q;
  end
  // register state, FIFO storage and held-key slots
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < CHANNELS; i++) held_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      if (acc && !flush) mem_q[wr_ptr_q] <= writedata[WIDTH-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (wr && address == ADDR_W'(4 + i)) held_q[i] <= writedata[WIDTH-1:0];
    end
  end
  // register map read mux; unmapped addresses read zero
  always_comb begin
    readdata = address == ADDR_W'(0) ? (ev_valid ? 32'(ev_data) : 32'h0) :
               address == ADDR_W'(1) ? {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty} :
               address == ADDR_W'(2) ? {30'h0, irq_en_q, en_q} : 32'h0;
    for (int i = 0; i < CHANNELS; i++)
      if (address == ADDR_W'(4 + i)) readdata = 32'(held_q[i]);
  end
endmodule
